// File: rtl/pwm_fade_ctrl.sv
// PWM duty-cycle sequencer: free-running period counter, registered pulse, and a
// valid/ready-fed ramp toward a target duty. Define PWM_FADE_RETARGET_EN to accept retargets mid-ramp.
module pwm_fade_ctrl #(
  parameter int PERIOD = 100,
  parameter int DUTY_W = 8,
  parameter int STEP   = 1,
  parameter int DWELL  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DUTY_W-1:0] i_target,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_pulse,
  output logic              o_period_start,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [DW_W-1:0]   DW_LAST  = DW_W'(DWELL - 1);
  localparam logic [DUTY_W:0]   STEP_X   = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W-1:0] STEP_N   = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [DW_W-1:0]   dwell, dwell_d;
  logic [DUTY_W-1:0] tgt, tgt_d, duty_d, req, cnt_x;
  logic [DUTY_W:0]   up_sum, dn_floor;
  logic              done_d, accept, boundary;

  assign req      = (i_target > DUTY_MAX) ? DUTY_MAX : i_target;
`ifdef PWM_FADE_RETARGET_EN
  assign o_ready  = 1'b1;
`else
  assign o_ready  = (state == IDLE);
`endif
  assign accept   = i_valid && o_ready;
  assign boundary = (cnt == CNT_LAST);
  assign o_busy   = (state != IDLE);
  assign cnt_x    = DUTY_W'(cnt);
  // One extra bit so up-steps never wrap and the down-step floor test never underflows.
  assign up_sum   = {1'b0, o_duty} + STEP_X;
  assign dn_floor = {1'b0, tgt} + STEP_X;

  always_comb begin
    state_d = state;
    tgt_d   = tgt;
    dwell_d = dwell;
    duty_d  = o_duty;
    done_d  = 1'b0;
    if (accept) begin
      // A new request (or a retarget) restarts the dwell and picks direction from the live duty.
      tgt_d   = req;
      dwell_d = '0;
      if (req > o_duty)      state_d = UP;
      else if (req < o_duty) state_d = DOWN;
      else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (state != IDLE && boundary) begin
      if (dwell == DW_LAST) begin
        dwell_d = '0;
        if (state == UP) duty_d = (up_sum > {1'b0, tgt}) ? tgt : up_sum[DUTY_W-1:0];
        else             duty_d = ({1'b0, o_duty} < dn_floor) ? tgt : o_duty - STEP_N;
        if (duty_d == tgt) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        dwell_d = dwell + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      dwell          <= '0;
      tgt            <= '0;
      o_duty         <= '0;
      o_pulse        <= 1'b0;
      o_period_start <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= boundary ? '0 : cnt + 1'b1;
      dwell          <= dwell_d;
      tgt            <= tgt_d;
      o_duty         <= duty_d;
      o_pulse        <= (cnt_x < o_duty);
      o_period_start <= (cnt == '0);
      o_done         <= done_d;
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: two instances (STEP=1 and STEP=3), PERIOD=8, DUTY_W=4, DWELL=2.
module tb_pwm_fade_ctrl;

  typedef struct {
    logic [3:0] duty;
    logic       last;
    logic       first;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] tgt_in [2];
  logic       valid  [2];
  logic       ready  [2];
  logic [3:0] duty   [2];
  logic       pulse  [2];
  logic       pstart [2];
  logic       busy   [2];
  logic       done   [2];

  exp_t q0[$];
  exp_t q1[$];
  int   pass = 0;
  int   total = 0;
  int   cyc = 0;
  int   done_cnt [2];
  int   last_cyc [2];
  logic [3:0] prev [2];

  always #5 clk = ~clk;

  pwm_fade_ctrl #(.PERIOD(8), .DUTY_W(4), .STEP(1), .DWELL(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_target(tgt_in[0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_duty(duty[0]), .o_pulse(pulse[0]),
    .o_period_start(pstart[0]), .o_busy(busy[0]), .o_done(done[0]));

  pwm_fade_ctrl #(.PERIOD(8), .DUTY_W(4), .STEP(3), .DWELL(2)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_target(tgt_in[1]), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_duty(duty[1]), .o_pulse(pulse[1]),
    .o_period_start(pstart[1]), .o_busy(busy[1]), .o_done(done[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Independent ramp model: clamp to PERIOD, step toward target, saturate at it.
  task automatic push_ramp(input int k, input int from, input int t);
    int   to = (t > 8) ? 8 : t;
    int   d = from;
    int   st = (k == 0) ? 1 : 3;
    logic first = 1'b1;
    exp_t e;
    while (d != to) begin
      if (to > d) d = (d + st > to) ? to : d + st;
      else        d = (d - st < to) ? to : d - st;
      e.duty = 4'(d); e.last = (d == to); e.first = first;
      first = 1'b0;
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic send(input int k, input logic [3:0] t);
    int n = 0;
    @(negedge clk);
    while (!ready[k] && n < 200) begin @(negedge clk); n++; end
    chk("send_ready", ready[k], 1);
    valid[k] = 1'b1; tgt_in[k] = t;
    @(posedge clk); #1;
    valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    @(negedge clk);
    while ((busy[k] || (k == 0 ? q0.size() : q1.size()) != 0) && n < 400) begin
      @(negedge clk); n++;
    end
    chk("idle_timeout", n < 400, 1);
  endtask

  task automatic wait_duty(input int k, input logic [3:0] v);
    int n = 0;
    @(negedge clk);
    while (duty[k] !== v && n < 400) begin @(negedge clk); n++; end
    chk("duty_wait_timeout", n < 400, 1);
    @(negedge clk);
  endtask

  // Counts high cycles over n cycles, starting at a period-start strobe.
  task automatic count_high(input int k, input int n, output int hi, output logic p0);
    int w = 0;
    hi = 0;
    @(negedge clk);
    while (!pstart[k] && w < 20) begin @(negedge clk); w++; end
    chk("pstart_wait", w < 20, 1);
    p0 = pulse[k];
    for (int i = 0; i < n; i++) begin
      if (pulse[k]) hi++;
      if (i != n - 1) @(negedge clk);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Duty monitor: every observed change must match the head of its scoreboard queue.
  initial begin
    exp_t e;
    done_cnt[0] = 0; done_cnt[1] = 0;
    last_cyc[0] = 0; last_cyc[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) prev[k] = duty[k];
        else begin
          if (done[k]) done_cnt[k]++;
          if (duty[k] !== prev[k]) begin
            if ((k == 0 ? q0.size() : q1.size()) == 0) chk("unexpected_duty_change", duty[k], prev[k]);
            else begin
              e = (k == 0) ? q0.pop_front() : q1.pop_front();
              chk("duty_step", duty[k], e.duty);
              chk("done_at_step", done[k], e.last);
              if (!e.first) chk("step_dwell_cycles", cyc - last_cyc[k], 16);
            end
            last_cyc[k] = cyc;
            prev[k] = duty[k];
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   hi, c0, dc;
    logic p0;
    valid[0] = 0; valid[1] = 0; tgt_in[0] = 0; tgt_in[1] = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_duty", duty[0], 0);
    chk("rst_pulse", pulse[0], 0);
    chk("rst_ready", ready[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_pstart", pstart[0], 0);
    chk("rst_done", done[0], 0);
    rst_n = 1'b1;

    // Period-start strobe cadence
    count_high(0, 1, hi, p0);
    c0 = cyc;
    count_high(0, 1, hi, p0);
    chk("pstart_period", cyc - c0, 8);

    // Up ramp 0 -> 3
    push_ramp(0, 0, 3);
    send(0, 4'd3);
    @(negedge clk);
    chk("busy_after_accept", busy[0], 1);
    chk("ready_while_busy", ready[0],
`ifdef PWM_FADE_RETARGET_EN
      1
`else
      0
`endif
    );
    wait_idle(0);
    chk("up_done_count", done_cnt[0], 1);
    count_high(0, 8, hi, p0);
    chk("duty3_high_cycles", hi, 3);
    chk("duty3_pulse_at_pstart", p0, 1);

    // Clamp: target 12 stops at 8 (full-high)
    push_ramp(0, 3, 12);
    send(0, 4'd12);
    wait_idle(0);
    chk("clamp_duty", duty[0], 8);
    count_high(0, 16, hi, p0);
    chk("clamp_high_cycles", hi, 16);

    // Equal target: done next cycle, never busy
    send(0, 4'd8);
    @(negedge clk);
    chk("equal_done", done[0], 1);
    chk("equal_busy", busy[0], 0);
    @(negedge clk);
    chk("equal_done_count", done_cnt[0], 3);

    // STEP=3 instance: up to 8 then down to 0 without wrap
    push_ramp(1, 0, 8);
    send(1, 4'd8);
    wait_idle(1);
    push_ramp(1, 8, 0);
    send(1, 4'd0);
    wait_idle(1);
    chk("step3_final_duty", duty[1], 0);
    chk("step3_done_count", done_cnt[1], 2);

    // Down ramp from 8, hold-off while busy, then reset mid-ramp
    push_ramp(0, 8, 0);
    send(0, 4'd0);
`ifndef PWM_FADE_RETARGET_EN
    @(negedge clk);
    valid[0] = 1'b1; tgt_in[0] = 4'd12;
    repeat (20) @(negedge clk);
    chk("holdoff_ready", ready[0], 0);
    chk("holdoff_busy", busy[0], 1);
    valid[0] = 1'b0;
`endif
    wait_duty(0, 4'd5);
    dc = done_cnt[0];
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_duty", duty[0], 0);
    chk("midrst_pulse", pulse[0], 0);
    chk("midrst_pstart", pstart[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_ready", ready[0], 1);
    chk("midrst_done", done[0], 0);
    q0.delete();
    q1.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_done", done_cnt[0], dc);

`ifdef PWM_FADE_RETARGET_EN
    // Retarget: ramp toward 6, redirect to 1 at duty 2
    push_ramp(0, 0, 6);
    send(0, 4'd6);
    wait_duty(0, 4'd2);
    q0.delete();
    push_ramp(0, 2, 1);
    send(0, 4'd1);
    wait_idle(0);
    chk("retarget_duty", duty[0], 1);
    chk("retarget_done_count", done_cnt[0], dc + 1);
`endif

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
